flash_loader_ctrl: RTL and testbench

//  Sequences UART program download into program memory; fetch-stage flash datapath only carries the writes.

---
 rtl/flash_loader_ctrl_pkg.sv | 16 +
 rtl/flash_loader_ctrl_if.sv | 29 ++
 rtl/flash_loader_ctrl.sv | 178 +++++++++++++++++
 tb/tb_flash_loader_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/flash_loader_ctrl_pkg.sv
// Shared types for the UART flash loader: FSM state encoding and length-prefix size.
package flash_loader_ctrl_pkg;

  localparam int FLASH_LEN_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LEN,
    DATA,
    CHECK,
    DONE,
    ERROR
  } flash_state_type;

endpackage

// File: rtl/flash_loader_ctrl_if.sv
// Loader bus: UART byte input, flash request, program-memory write port and status.
interface flash_loader_ctrl_if
  import flash_loader_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic              flash_req;
  logic [7:0]        uart_data;
  logic              uart_received;
  logic              flash;
  logic              clear_mem;
  logic              write_enable;
  logic [ADDR_W-1:0] write_address;
  logic [7:0]        write_data;
  logic              load_done;
  logic              load_error;

  modport master (
    input  flash_req, uart_data, uart_received,
    output flash, clear_mem, write_enable, write_address, write_data, load_done, load_error
  );

  modport slave (
    output flash_req, uart_data, uart_received,
    input  flash, clear_mem, write_enable, write_address, write_data, load_done, load_error
  );

endinterface

// File: rtl/flash_loader_ctrl.sv
// UART length-prefixed program download into memory; write strobe 1 cycle after each byte, no backpressure.
// Optional FLASH_CHECKSUM_EN: a trailing XOR-of-payload byte must match before load_done.
module flash_loader_ctrl
  import flash_loader_ctrl_pkg::*;
#(
  parameter int MEM_BYTES      = 4096,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic                 clk,
  input logic                 rst,
  flash_loader_ctrl_if.master bus
);

  flash_state_type   state_q, state_d;
  logic              req_q;
  logic [7:0]        clr_cnt_q, clr_cnt_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]       idle_q, idle_d;
`ifdef FLASH_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              flash_q, clear_mem_q, write_enable_q, load_done_q, load_error_q;
  logic [ADDR_W-1:0] write_address_q;
  logic [7:0]        write_data_q;

  logic              req_rise, start, loading, rx, timed_out, wr_fire;
  logic [31:0]       new_len;

  assign req_rise  = bus.flash_req & ~req_q;
  assign start     = (state_q == IDLE) & req_rise;
  assign loading   = state_q inside {CLEAR, LEN, DATA, CHECK};
  assign rx        = bus.uart_received;
  assign timed_out = idle_q >= 32'(TIMEOUT_CYCLES - 1);
  assign new_len   = {bus.uart_data, len_q[31:8]};

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    idle_d     = 32'd0;
    wr_fire    = 1'b0;
`ifdef FLASH_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CLEAR;
          clr_cnt_d  = 8'd0;
          len_d      = 32'd0;
          byte_cnt_d = 32'd0;
`ifdef FLASH_CHECKSUM_EN
          csum_d     = 8'd0;
`endif
        end
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 8'd1;
        if (clr_cnt_q == 8'(CLEAR_CYCLES - 1)) state_d = LEN;
      end
      LEN: begin
        idle_d = idle_q + 32'd1;
        if (rx) begin
          idle_d     = 32'd0;
          len_d      = new_len;
          byte_cnt_d = byte_cnt_q + 32'd1;
          if (byte_cnt_q == 32'(FLASH_LEN_BYTES - 1)) begin
            byte_cnt_d = 32'd0;
            if (new_len == 32'd0)                 state_d = DONE;
            else if (new_len > 32'(MEM_BYTES))    state_d = ERROR;
            else                                  state_d = DATA;
          end
        end else if (timed_out) begin
          state_d = ERROR;
        end
      end
      DATA: begin
        idle_d = idle_q + 32'd1;
        if (rx) begin
          idle_d     = 32'd0;
          wr_fire    = 1'b1;
          byte_cnt_d = byte_cnt_q + 32'd1;
`ifdef FLASH_CHECKSUM_EN
          csum_d     = csum_q ^ bus.uart_data;
          if (byte_cnt_q == len_q - 32'd1) state_d = CHECK;
`else
          if (byte_cnt_q == len_q - 32'd1) state_d = DONE;
`endif
        end else if (timed_out) begin
          state_d = ERROR;
        end
      end
`ifdef FLASH_CHECKSUM_EN
      CHECK: begin
        idle_d = idle_q + 32'd1;
        if (rx)             state_d = (bus.uart_data == csum_q) ? DONE : ERROR;
        else if (timed_out) state_d = ERROR;
      end
`endif
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Dropping the request aborts; a byte in the same cycle is not written.
    if (loading && !bus.flash_req) begin
      state_d = ERROR;
      wr_fire = 1'b0;
    end
  end

  // req_q resets high so a request already held through reset is not seen as a new edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= bus.flash_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt_q  <= 8'd0;
      len_q      <= 32'd0;
      byte_cnt_q <= 32'd0;
      idle_q     <= 32'd0;
`ifdef FLASH_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      clr_cnt_q  <= clr_cnt_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      idle_q     <= idle_d;
`ifdef FLASH_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_q         <= 1'b0;
      clear_mem_q     <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= 8'd0;
      load_done_q     <= 1'b0;
      load_error_q    <= 1'b0;
    end else begin
      flash_q        <= state_d inside {CLEAR, LEN, DATA, CHECK};
      clear_mem_q    <= state_d == CLEAR;
      write_enable_q <= wr_fire;
      load_done_q    <= state_d == DONE;
      if (wr_fire) begin
        write_address_q <= ADDR_W'(byte_cnt_q);
        write_data_q    <= bus.uart_data;
      end
      if (start)                 load_error_q <= 1'b0;
      else if (state_d == ERROR) load_error_q <= 1'b1;
    end
  end

  assign bus.flash         = flash_q;
  assign bus.clear_mem     = clear_mem_q;
  assign bus.write_enable  = write_enable_q;
  assign bus.write_address = write_address_q;
  assign bus.write_data    = write_data_q;
  assign bus.load_done     = load_done_q;
  assign bus.load_error    = load_error_q;

endmodule

// File: tb/tb_flash_loader_ctrl.sv
// Self-checking bench for flash_loader_ctrl; expected writes are queued as bytes are sent.
module tb_flash_loader_ctrl;

  localparam int TMO = 64;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_wr = 0;
  int   n_clr = 0;
  int   n_done = 0;
  logic [7:0] x_acc;
  wr_t  exp_q[$];

  flash_loader_ctrl_if #(.ADDR_W(32)) bus ();

  flash_loader_ctrl #(
    .MEM_BYTES(4096),
    .ADDR_W(32),
    .CLEAR_CYCLES(4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.clear_mem) n_clr++;
    if (bus.load_done) n_done++;
    if (bus.write_enable) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", bus.write_address, e.addr);
        check("wr_data", {24'd0, bus.write_data}, {24'd0, e.data});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.uart_data     = b;
    bus.uart_received = 1'b1;
    @(negedge clk);
    bus.uart_received = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send_byte(8'((n >> (8 * i)) & 32'hFF));
  endtask

  task automatic send_data(input logic [31:0] addr, input logic [7:0] b);
    wr_t e;
    e.addr = addr;
    e.data = b;
    exp_q.push_back(e);
    x_acc = x_acc ^ b;
    send_byte(b);
  endtask

  task automatic send_trailer();
`ifdef FLASH_CHECKSUM_EN
    send_byte(x_acc);
`endif
  endtask

  // Re-arms the request, drops one byte into CLEAR and waits until LEN.
  task automatic start_load();
    @(negedge clk);
    bus.flash_req = 1'b0;
    @(negedge clk);
    bus.flash_req = 1'b1;
    n_wr = 0; n_clr = 0; n_done = 0;
    x_acc = 8'd0;
    send_byte(8'hEE);
    repeat (6) @(negedge clk);
    check("clear_cycles", n_clr, 4);
  endtask

  initial begin
    int cyc;
    bus.flash_req     = 1'b0;
    bus.uart_data     = 8'd0;
    bus.uart_received = 1'b0;
    x_acc             = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_flash", bus.flash, 0);
    check("rst_clear", bus.clear_mem, 0);
    check("rst_we", bus.write_enable, 0);
    check("rst_addr", bus.write_address, 0);
    check("rst_done", bus.load_done, 0);
    check("rst_err", bus.load_error, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // N=8 payload 11..18
    start_load();
    check("t1_flash", bus.flash, 1);
    send_len(32'd8);
    send_data(32'd0, 8'h11);
    check("t1_wr_latency", bus.write_enable, 1);
    for (int i = 1; i < 8; i++) send_data(i, 8'(8'h11 + i));
    send_trailer();
    check("t1_done_pulse", bus.load_done, 1);
    check("t1_flash_off", bus.flash, 0);
    @(negedge clk);
    check("t1_done_single", bus.load_done, 0);
    check("t1_nwr", n_wr, 8);
    check("t1_ndone", n_done, 1);
    check("t1_err", bus.load_error, 0);

    // N=0
    start_load();
    send_len(32'd0);
    check("t2_done_pulse", bus.load_done, 1);
    @(negedge clk);
    check("t2_nwr", n_wr, 0);
    check("t2_ndone", n_done, 1);

    // N=MEM_BYTES+1 rejected; held request must not restart
    start_load();
    send_len(32'd4097);
    check("t3_err", bus.load_error, 1);
    check("t3_flash", bus.flash, 0);
    n_clr = 0;
    repeat (8) @(negedge clk);
    check("t3_no_restart", n_clr, 0);
    check("t3_nwr", n_wr, 0);
    start_load();
    check("t3_err_cleared", bus.load_error, 0);
    send_len(32'd2);
    send_data(32'd0, 8'h21);
    send_data(32'd1, 8'h22);
    send_trailer();
    @(negedge clk);
    check("t3_reload_ndone", n_done, 1);
    check("t3_reload_nwr", n_wr, 2);

    // timeout after 3 of 4 payload bytes
    start_load();
    send_len(32'd4);
    for (int i = 0; i < 3; i++) send_data(i, 8'(8'h30 + i));
    cyc = 0;
    while (!bus.load_error && cyc < 4 * TMO) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_tmo_cycles", cyc, TMO);
    check("t4_err", bus.load_error, 1);
    check("t4_nwr", n_wr, 3);
    check("t4_flash", bus.flash, 0);

    // async reset mid-DATA with request held high
    start_load();
    send_len(32'd4);
    send_data(32'd0, 8'h41);
    send_data(32'd1, 8'h42);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_flash", bus.flash, 0);
    check("t5_rst_we", bus.write_enable, 0);
    check("t5_rst_addr", bus.write_address, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    n_clr = 0;
    repeat (10) @(negedge clk);
    check("t5_no_restart_flash", bus.flash, 0);
    check("t5_no_restart_clr", n_clr, 0);
    check("t5_err", bus.load_error, 0);

    // N=MEM_BYTES accepted, then request dropped mid-DATA
    start_load();
    send_len(32'd4096);
    check("t6_len_ok_flash", bus.flash, 1);
    check("t6_len_ok_err", bus.load_error, 0);
    send_data(32'd0, 8'h5A);
    @(negedge clk);
    bus.flash_req = 1'b0;
    @(negedge clk);
    check("t6_abort_err", bus.load_error, 1);
    check("t6_abort_flash", bus.flash, 0);
    repeat (3) @(negedge clk);
    check("t6_abort_nwr", n_wr, 1);

`ifdef FLASH_CHECKSUM_EN
    start_load();
    send_len(32'd2);
    send_data(32'd0, 8'hAA);
    send_data(32'd1, 8'h55);
    send_byte(8'hFF);
    check("t7_csum_done", bus.load_done, 1);
    check("t7_csum_err", bus.load_error, 0);
    start_load();
    send_len(32'd2);
    send_data(32'd0, 8'hAA);
    send_data(32'd1, 8'h55);
    send_byte(8'h00);
    check("t7_bad_err", bus.load_error, 1);
    check("t7_bad_done", n_done, 0);
    check("t7_bad_nwr", n_wr, 2);
`endif

    repeat (3) @(negedge clk);
    check("end_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
